guess_game_core: RTL and testbench

Parametrised number-guessing engine: draws a secret from a free-running LFSR, accumulates decimal key digits into a guess, and narrows the live lower/upper limits after each guess. Adds an attempt limit, win/lose outcome and a deterministic secret-load path for test. Sits between the DIP key decoder (which supplies one-hot-decoded digits) and the display/LED logic.

---
 rtl/guess_game_core.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_guess_game_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_core.sv
// ---------------------------------------------------------------------------
// guess_game_core
//
// Number-guessing engine. A secret is drawn from a free-running Fibonacci
// LFSR, or forced from fix_val for deterministic play. Decimal key digits
// accumulate into a guess. Each submitted guess narrows the live lower and
// upper limits toward the secret. The game ends in WIN when the guess matches.
// It ends in LOSE when MAX_TRIES in-range guesses have been used without a
// match.
//
// Optional build macro:
//   TIMEOUT_EN - when defined, sitting idle in ENTRY for TIMEOUT_CYC cycles
//                consumes one try and discards any partial guess.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   pulse: begin/restart a game (beats enter/digit_valid)
//   fix_en       in   sampled with start: use fix_val as the secret
//   fix_val      in   [DW] forced secret value
//   digit_valid  in   one-cycle strobe, digit is valid
//   digit        in   [4] decimal digit 0..9
//   enter        in   one-cycle strobe: submit the accumulated guess
//   guess        out  [DW] current accumulated/submitted guess
//   lo_lim       out  [DW] current lower limit
//   hi_lim       out  [DW] current upper limit
//   tries        out  [4] in-range guesses consumed
//   too_low      out  last guess < secret
//   too_high     out  last guess > secret
//   outrange     out  last guess outside [lo_lim, hi_lim]
//   win          out  game won (level)
//   lose         out  game lost (level)
//   busy         out  state is DRAW or CHECK
//   state        out  [3] FSM state code, for debug
// ---------------------------------------------------------------------------
module guess_game_core #(
  parameter int                  DW          = 8,
  parameter int                  MIN_VAL     = 1,
  parameter int                  MAX_VAL     = 99,
  parameter int                  DIGITS      = 2,
  parameter int                  MAX_TRIES   = 7,
  parameter int                  LFSR_W      = 16,
  parameter logic [LFSR_W-1:0]   LFSR_SEED   = LFSR_W'(16'hACE1),
  parameter int                  TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fix_en,
  input  logic [DW-1:0] fix_val,
  input  logic          digit_valid,
  input  logic [3:0]    digit,
  input  logic          enter,
  output logic [DW-1:0] guess,
  output logic [DW-1:0] lo_lim,
  output logic [DW-1:0] hi_lim,
  output logic [3:0]    tries,
  output logic          too_low,
  output logic          too_high,
  output logic          outrange,
  output logic          win,
  output logic          lose,
  output logic          busy,
  output logic [2:0]    state
);

  // FSM state codes (fixed values; the debug port exposes them directly)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAW  = 3'd1;
  localparam logic [2:0] S_ENTRY = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  localparam int              CW        = (DIGITS < 1) ? 1 : $clog2(DIGITS + 1);
  localparam logic [DW-1:0]   MIN_V     = DW'(MIN_VAL);
  localparam logic [DW-1:0]   MAX_V     = DW'(MAX_VAL);
  localparam logic [DW-1:0]   SAT_V     = '1;
  localparam logic [CW-1:0]   DIG_MAX   = CW'(DIGITS);
  localparam logic [3:0]      TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [DW+3:0]   TEN       = (DW + 4)'(10);

  // Feedback tap masks for maximal-length Fibonacci LFSRs (shift toward the
  // MSB, feedback into bit 0). Widths without a table entry fall back to the
  // two top bits. That fallback still never locks up at zero, but it may
  // not give the full period.
  function automatic logic [LFSR_W-1:0] lfsrMask();
    logic [63:0] m;
    case (LFSR_W)
      8:       m = 64'h0000_0000_0000_00B8;
      12:      m = 64'h0000_0000_0000_0E08;
      16:      m = 64'h0000_0000_0000_B400;
      24:      m = 64'h0000_0000_00E1_0000;
      32:      m = 64'h0000_0000_8020_0003;
      default: m = 64'h3 << (LFSR_W - 2);
    endcase
    return m[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] LFSR_MASK = lfsrMask();

  logic [2:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [DW-1:0]     guess_q, guess_d;
  logic [DW-1:0]     lo_q, lo_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [DW-1:0]     secret_q, secret_d;
  logic [DW-1:0]     fixVal_q, fixVal_d;
  logic              fix_q, fix_d;
  logic [3:0]        tries_q, tries_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tooLow_q, tooLow_d;
  logic              tooHigh_q, tooHigh_d;
  logic              outrange_q, outrange_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic              lfsrFb;
  logic              lfsrInRange;
  logic              fixInRange;
  logic [DW+3:0]     wideAcc;
  logic [DW-1:0]     accVal;
  logic [3:0]        triesInc;
  logic              enterAcc;
  logic              digitAcc;
  logic              tmoHit;

  // The LFSR runs every cycle regardless of state, so the moment start is
  // pressed decides which value gets drawn.
  assign lfsrFb = ^(lfsr_q & LFSR_MASK);
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsrFb};

  assign lfsrInRange = (lfsr_q[DW-1:0] >= MIN_V) && (lfsr_q[DW-1:0] <= MAX_V);
  assign fixInRange  = (fix_val >= MIN_V) && (fix_val <= MAX_V);

  // Decimal shift-in of the next digit. The extra 4 bits hold the worst case
  // (all-ones * 10 + 9), so the saturation test below is exact.
  assign wideAcc  = {4'b0000, guess_q} * TEN + {{DW{1'b0}}, digit};
  assign accVal   = (wideAcc > {4'b0000, SAT_V}) ? SAT_V : wideAcc[DW-1:0];
  assign triesInc = tries_q + 4'd1;

  // enter takes priority over a digit in the same cycle. An enter with no
  // digits typed does nothing, and the digit from that cycle is still dropped.
  assign enterAcc = (state_q == S_ENTRY) && enter && (cnt_q != '0);
  assign digitAcc = (state_q == S_ENTRY) && !enter && digit_valid &&
                    (digit <= 4'd9) && (cnt_q < DIG_MAX);

`ifdef TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Idle counter for ENTRY. It restarts on any accepted key and whenever the
  // state changes, so only true inactivity inside ENTRY builds up.
  assign tmoHit = (state_q == S_ENTRY) && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = '0;
    if ((state_q == S_ENTRY) && !start && !enterAcc && !digitAcc && !tmoHit) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // Without the timeout, ENTRY waits indefinitely. TIMEOUT_CYC stays in the
  // parameter list so both builds share one interface.
  assign tmoHit = 1'b0;
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  // Next-state and datapath logic. start overrides everything, including
  // a game that is still in progress.
  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    secret_d   = secret_q;
    fixVal_d   = fixVal_q;
    fix_d      = fix_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    tooLow_d   = tooLow_q;
    tooHigh_d  = tooHigh_q;
    outrange_d = outrange_q;
    win_d      = win_q;
    lose_d     = lose_q;

    if (start) begin
      state_d    = S_DRAW;
      guess_d    = '0;
      lo_d       = MIN_V;
      hi_d       = MAX_V;
      tries_d    = '0;
      cnt_d      = '0;
      tooLow_d   = 1'b0;
      tooHigh_d  = 1'b0;
      outrange_d = 1'b0;
      win_d      = 1'b0;
      lose_d     = 1'b0;
      // An out-of-range forced value is simply not latched as forced, so
      // DRAW falls back to the LFSR.
      fix_d      = fix_en && fixInRange;
      fixVal_d   = fix_val;
    end else begin
      case (state_q)
        S_DRAW: begin
          // Rejection sampling: out-of-range LFSR values are skipped and
          // the next cycle's value is tried instead.
          if (fix_q) begin
            secret_d = fixVal_q;
            state_d  = S_ENTRY;
          end else if (lfsrInRange) begin
            secret_d = lfsr_q[DW-1:0];
            state_d  = S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (enterAcc) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else if (digitAcc) begin
            // The first digit starts a fresh guess and clears the previous
            // verdict.
            if (cnt_q == '0) begin
              guess_d    = DW'(digit);
              tooLow_d   = 1'b0;
              tooHigh_d  = 1'b0;
              outrange_d = 1'b0;
            end else begin
              guess_d = accVal;
            end
            cnt_d = cnt_q + CW'(1);
          end else if (tmoHit) begin
            tries_d = triesInc;
            guess_d = '0;
            cnt_d   = '0;
            if (triesInc == TRIES_MAX) begin
              lose_d  = 1'b1;
              state_d = S_LOSE;
            end
          end
        end

        S_CHECK: begin
          // An out-of-range guess is only flagged and costs nothing.
          if ((guess_q < lo_q) || (guess_q > hi_q)) begin
            outrange_d = 1'b1;
            state_d    = S_ENTRY;
          end else begin
            tries_d = triesInc;
            if (guess_q == secret_q) begin
              win_d   = 1'b1;
              lo_d    = secret_q;
              hi_d    = secret_q;
              state_d = S_WIN;
            end else begin
              if (guess_q < secret_q) begin
                tooLow_d = 1'b1;
                lo_d     = guess_q + DW'(1);
              end else begin
                tooHigh_d = 1'b1;
                hi_d      = guess_q - DW'(1);
              end
              if (triesInc == TRIES_MAX) begin
                lose_d  = 1'b1;
                state_d = S_LOSE;
              end else begin
                state_d = S_ENTRY;
              end
            end
          end
        end

        S_IDLE, S_WIN, S_LOSE: begin
          // Keys are ignored here; only start (handled above) leaves.
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers. Reset returns the engine to a blank IDLE game with the
  // LFSR reseeded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      guess_q    <= '0;
      lo_q       <= MIN_V;
      hi_q       <= MAX_V;
      secret_q   <= '0;
      fixVal_q   <= '0;
      fix_q      <= 1'b0;
      tries_q    <= '0;
      cnt_q      <= '0;
      tooLow_q   <= 1'b0;
      tooHigh_q  <= 1'b0;
      outrange_q <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      guess_q    <= guess_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      secret_q   <= secret_d;
      fixVal_q   <= fixVal_d;
      fix_q      <= fix_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      tooLow_q   <= tooLow_d;
      tooHigh_q  <= tooHigh_d;
      outrange_q <= outrange_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign guess    = guess_q;
  assign lo_lim   = lo_q;
  assign hi_lim   = hi_q;
  assign tries    = tries_q;
  assign too_low  = tooLow_q;
  assign too_high = tooHigh_q;
  assign outrange = outrange_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign busy     = (state_q == S_DRAW) || (state_q == S_CHECK);
  assign state    = state_q;

endmodule

// File: tb/tb_guess_game_core.sv
// ---------------------------------------------------------------------------
// tb_guess_game_core
//
// Directed bench for guess_game_core. The main instance uses default
// parameters, with TIMEOUT_CYC=20 for builds that define TIMEOUT_EN. A
// second instance with MAX_TRIES=3 shares every input and exercises the
// LOSE path.
// ---------------------------------------------------------------------------
module tb_guess_game_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fix_en;
  logic [7:0] fix_val;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;

  logic [7:0] guess, lo_lim, hi_lim;
  logic [3:0] tries;
  logic       too_low, too_high, outrange, win, lose, busy;
  logic [2:0] state;

  logic [7:0] guess3, lo_lim3, hi_lim3;
  logic [3:0] tries3;
  logic       too_low3, too_high3, outrange3, win3, lose3, busy3;
  logic [2:0] state3;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  guess_game_core #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .start(start), .fix_en(fix_en), .fix_val(fix_val),
    .digit_valid(digit_valid), .digit(digit), .enter(enter),
    .guess(guess), .lo_lim(lo_lim), .hi_lim(hi_lim), .tries(tries),
    .too_low(too_low), .too_high(too_high), .outrange(outrange),
    .win(win), .lose(lose), .busy(busy), .state(state)
  );

  guess_game_core #(.MAX_TRIES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .fix_en(fix_en), .fix_val(fix_val),
    .digit_valid(digit_valid), .digit(digit), .enter(enter),
    .guess(guess3), .lo_lim(lo_lim3), .hi_lim(hi_lim3), .tries(tries3),
    .too_low(too_low3), .too_high(too_high3), .outrange(outrange3),
    .win(win3), .lose(lose3), .busy(busy3), .state(state3)
  );

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic startGame(input logic fen, input logic [7:0] fval);
    start = 1'b1; fix_en = fen; fix_val = fval;
    tick();
    start = 1'b0; fix_en = 1'b0; fix_val = 8'd0;
  endtask

  task automatic pushDigit(input logic [3:0] d);
    digit_valid = 1'b1; digit = d;
    tick();
    digit_valid = 1'b0; digit = 4'd0;
  endtask

  task automatic pushEnter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  // Type a decimal value, submit it, and wait through CHECK.
  task automatic applyStimulus(input int v);
    if (v >= 10) begin
      pushDigit(4'(v / 10));
      pushDigit(4'(v % 10));
    end else begin
      pushDigit(4'(v));
    end
    pushEnter();
    tick();
  endtask

  task automatic waitDraw(input string tag);
    int n = 0;
    while (state == 3'd1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(state), 32'd2);
  endtask

  // Binary search over [1,99]; seven guesses always suffice for 99 values.
  task automatic playToWin(input string tag);
    int lo = 1;
    int hi = 99;
    int mid;
    for (int k = 0; k < 7 && win !== 1'b1; k++) begin
      mid = (lo + hi) / 2;
      applyStimulus(mid);
      if (too_low === 1'b1) lo = mid + 1;
      else if (too_high === 1'b1) hi = mid - 1;
    end
    checkOutput({tag, "_win"}, 32'(win), 32'd1);
    checkOutput({tag, "_secret_range"},
                32'((lo_lim >= 8'd1) && (lo_lim <= 8'd99) && (lo_lim == hi_lim)), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; fix_en = 1'b0; fix_val = 8'd0;
    digit_valid = 1'b0; digit = 4'd0; enter = 1'b0;
    repeat (3) tick();

    // Reset values on both instances
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_guess", 32'(guess), 32'd0);
    checkOutput("rst_lo", 32'(lo_lim), 32'd1);
    checkOutput("rst_hi", 32'(hi_lim), 32'd99);
    checkOutput("rst_tries", 32'(tries), 32'd0);
    checkOutput("rst_flags", 32'({too_low, too_high, outrange, win, lose, busy}), 32'd0);
    checkOutput("rst3_all", 32'({state3, guess3, tries3}), 32'd0);
    checkOutput("rst3_lim", 32'({lo_lim3, hi_lim3}), 32'h0163);
    checkOutput("rst3_flags", 32'({too_low3, too_high3, outrange3, win3, lose3, busy3}), 32'd0);
    #2 rst = 1'b0;
    tick();

    // IDLE ignores keys
    pushDigit(4'd5);
    pushEnter();
    checkOutput("idle_guess", 32'(guess), 32'd0);
    checkOutput("idle_state", 32'(state), 32'd0);

    // Fixed secret 42: guess 50 then 42
    startGame(1'b1, 8'd42);
    checkOutput("a_draw_state", 32'(state), 32'd1);
    checkOutput("a_draw_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("a_entry_state", 32'(state), 32'd2);
    checkOutput("a_entry_busy", 32'(busy), 32'd0);
    pushDigit(4'd5);
    pushDigit(4'd0);
    checkOutput("a_guess50", 32'(guess), 32'd50);
    pushEnter();
    checkOutput("a_check_state", 32'(state), 32'd3);
    checkOutput("a_check_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("a_too_high", 32'(too_high), 32'd1);
    checkOutput("a_too_low", 32'(too_low), 32'd0);
    checkOutput("a_hi49", 32'(hi_lim), 32'd49);
    checkOutput("a_lo1", 32'(lo_lim), 32'd1);
    checkOutput("a_tries1", 32'(tries), 32'd1);
    checkOutput("a_back_entry", 32'(state), 32'd2);
    pushDigit(4'd4);
    checkOutput("a_first_digit_clears", 32'(too_high), 32'd0);
    checkOutput("a_first_digit_guess", 32'(guess), 32'd4);
    pushDigit(4'd2);
    pushEnter();
    tick();
    checkOutput("a_win", 32'(win), 32'd1);
    checkOutput("a_win_tries", 32'(tries), 32'd2);
    checkOutput("a_win_lo", 32'(lo_lim), 32'd42);
    checkOutput("a_win_hi", 32'(hi_lim), 32'd42);
    checkOutput("a_win_state", 32'(state), 32'd4);
    pushDigit(4'd7);
    pushEnter();
    checkOutput("a_win_hold_guess", 32'(guess), 32'd42);
    checkOutput("a_win_hold_state", 32'(state), 32'd4);

    // Fixed 42: guess 30 narrows low, then 20 is out of range
    startGame(1'b1, 8'd42);
    checkOutput("b_restart", 32'({state, tries, guess, win}), 32'({3'd1, 4'd0, 8'd0, 1'b0}));
    checkOutput("b_restart_lim", 32'({lo_lim, hi_lim}), 32'h0163);
    tick();
    applyStimulus(30);
    checkOutput("b_too_low", 32'(too_low), 32'd1);
    checkOutput("b_lo31", 32'(lo_lim), 32'd31);
    checkOutput("b_tries1", 32'(tries), 32'd1);
    applyStimulus(20);
    checkOutput("b_outrange", 32'(outrange), 32'd1);
    checkOutput("b_outrange_clear_low", 32'(too_low), 32'd0);
    checkOutput("b_outrange_tries", 32'(tries), 32'd1);
    checkOutput("b_outrange_lim", 32'({lo_lim, hi_lim}), 32'({8'd31, 8'd99}));
    checkOutput("b_outrange_state", 32'(state), 32'd2);

    // Empty enter, digit overflow, enter beating a digit
    pushEnter();
    checkOutput("d_empty_enter", 32'(state), 32'd2);
    tick();
    checkOutput("d_empty_enter_tries", 32'(tries), 32'd1);
    pushDigit(4'd1);
    pushDigit(4'd2);
    pushDigit(4'd3);
    checkOutput("d_third_dropped", 32'(guess), 32'd12);
    enter = 1'b1; digit_valid = 1'b1; digit = 4'd5;
    tick();
    enter = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    checkOutput("d_enter_wins_state", 32'(state), 32'd3);
    checkOutput("d_enter_wins_guess", 32'(guess), 32'd12);
    tick();
    checkOutput("d_check12_outrange", 32'({outrange, tries}), 32'({1'b1, 4'd1}));

    // start beats enter mid-entry; MAX_TRIES=3 instance loses on 10,20,30
    pushDigit(4'd3);
    start = 1'b1; enter = 1'b1; fix_en = 1'b1; fix_val = 8'd77;
    tick();
    start = 1'b0; enter = 1'b0; fix_en = 1'b0; fix_val = 8'd0;
    checkOutput("c_start_priority", 32'({state, guess}), 32'({3'd1, 8'd0}));
    tick();
    checkOutput("c3_entry", 32'(state3), 32'd2);
    applyStimulus(10);
    applyStimulus(20);
    checkOutput("c3_two_tries", 32'({lose3, state3, tries3}), 32'({1'b0, 3'd2, 4'd2}));
    applyStimulus(30);
    checkOutput("c3_lose", 32'(lose3), 32'd1);
    checkOutput("c3_lose_state", 32'(state3), 32'd5);
    checkOutput("c3_lose_tries", 32'(tries3), 32'd3);
    checkOutput("c3_lose_low", 32'({too_low3, lo_lim3}), 32'({1'b1, 8'd31}));
    checkOutput("c_default_not_lost", 32'({lose, state, tries}), 32'({1'b0, 3'd2, 4'd3}));
    pushDigit(4'd9);
    pushEnter();
    checkOutput("c3_lose_hold", 32'({guess3, state3, lose3}), 32'({8'd30, 3'd5, 1'b1}));
    startGame(1'b0, 8'd0);
    checkOutput("c3_restart", 32'({state3, tries3, lose3}), 32'({3'd1, 4'd0, 1'b0}));
    checkOutput("c3_restart_lim", 32'({lo_lim3, hi_lim3}), 32'h0163);

    // LFSR draws: each secret must be findable in [1,99]
    waitDraw("e_draw_first");
    playToWin("e_draw_first");
    for (int r = 0; r < 200; r++) begin
      startGame(1'b0, 8'd0);
      waitDraw("e_draw_loop");
      playToWin("e_draw_loop");
    end
    startGame(1'b1, 8'd150);
    waitDraw("e_fallback");
    playToWin("e_fallback");

    // Idle in ENTRY
    startGame(1'b1, 8'd42);
    tick();
`ifdef TIMEOUT_EN
    repeat (19) tick();
    checkOutput("t_before_timeout", 32'(tries), 32'd0);
    tick();
    checkOutput("t_timeout_try", 32'(tries), 32'd1);
    checkOutput("t_timeout_state", 32'(state), 32'd2);
`else
    repeat (30) tick();
    checkOutput("t_no_timeout", 32'({tries, state}), 32'({4'd0, 3'd2}));
`endif

    // Asynchronous reset while in CHECK
    startGame(1'b1, 8'd42);
    tick();
    applyStimulus(50);
    checkOutput("r_pre_state", 32'({hi_lim, tries}), 32'({8'd49, 4'd1}));
    pushDigit(4'd4);
    pushDigit(4'd5);
    pushEnter();
    checkOutput("r_in_check", 32'(state), 32'd3);
    #3 rst = 1'b1;
    #1;
    checkOutput("r_async_state", 32'(state), 32'd0);
    checkOutput("r_async_guess", 32'(guess), 32'd0);
    checkOutput("r_async_lim", 32'({lo_lim, hi_lim}), 32'h0163);
    checkOutput("r_async_tries", 32'(tries), 32'd0);
    checkOutput("r_async_flags", 32'({too_low, too_high, outrange, win, lose, busy}), 32'd0);
    #3 rst = 1'b0;
    tick();
    checkOutput("r_after_release", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
